instruction_fetch_unit: RTL

Front-end stage that feeds `processor_module` one 32-bit instruction per handshake. Holds a loadable 32-word program memory, a 5-bit program counter and a registered output slot. Stops fetching on the HALT opcode. Accepts absolute branch redirects from the execute stage, flushing the output slot.

---
 rtl/processor_pkg.sv | 29 ++
 rtl/program_mem.sv | 38 +++
 rtl/instruction_fetch_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// Shared definitions for the processor front end: widths, opcodes, fetch FSM
// encoding and the fetch output slot payload.
package processor_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned OPC_W  = 5;
    localparam int unsigned CNT_W  = 32;

    localparam logic [OPC_W-1:0] OP_NOP  = 5'b00000;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b00001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] word;
        logic [ADDR_W-1:0] pc;
    } fetch_slot_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [DATA_W-1:0] word);
        return word[DATA_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/program_mem.sv
// Program memory: one synchronous write port, one registered read port.
// A write to the address being read is forwarded so the read sees the new word.
module program_mem #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, IDLE/FETCH/HALT control, registered output slot and accept
// counter in front of a synchronous program memory.
module instruction_fetch_unit
    import processor_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instruction_format,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    fetch_slot_t       slot_q, slot_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_rdata;

    logic start_c, redirect_c, load_c, accept_c, mem_we_c;

    assign start_c    = start && (state_q != ST_FETCH);
    assign redirect_c = redirect_valid && (state_q != ST_IDLE);
    assign load_c     = (state_q == ST_FETCH) && (!valid_q || instr_ready)
                        && !redirect_valid && !start;
    assign accept_c   = valid_q && instr_ready;
    assign mem_we_c   = load_en && (state_q != ST_FETCH);

    // The memory is read at the next PC, so its output always holds mem[pc_q].
    program_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_program_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we_c),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (pc_d),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        slot_d  = slot_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        if (accept_c) begin
            valid_d = 1'b0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (start_c) begin
            pc_d    = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
            state_d = ST_FETCH;
        end else if (redirect_c) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            state_d = ST_FETCH;
        end else if (load_c) begin
            slot_d.word = mem_rdata;
            slot_d.pc   = pc_q;
            valid_d     = 1'b1;
            pc_d        = pc_q + ADDR_W'(1);
            if (opcode_of(mem_rdata) == OP_HALT) begin
                state_d = ST_HALT;
            end
        end

        halted_d = (state_d == ST_HALT) && !valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            slot_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            slot_q   <= slot_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign instr_valid        = valid_q;
    assign instruction_format = slot_q.word;
    assign instr_pc           = slot_q.pc;
    assign halted             = halted_q;
    assign fetch_count        = cnt_q;

endmodule
